d_latch_sync: RTL and testbench

//   Clock-domain-safe D latch for WIDTH-bit data.
//   - enable high: q follows d combinationally (transparent).
//   - enable low: q holds the value captured in a flop on the last clock edge

---
 rtl/d_latch_sync_pkg.sv | 16 +
 rtl/d_latch_sync.sv | 63 ++++++
 tb/tb_d_latch_sync.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/d_latch_sync_pkg.sv
// Shared definitions for the flop-based D latch.
//   DefWidth / DefCntW  : default data and open-window counter widths
//   window_opens()      : detects an enable 0->1 transition against the
//                         registered copy of enable
package d_latch_sync_pkg;

    localparam int unsigned DefWidth = 1;
    localparam int unsigned DefCntW  = 8;

    // A window opens on the first edge where enable is high after an edge
    // where it was low (or after reset, which clears the registered copy).
    function automatic logic window_opens(input logic en, input logic en_prev);
        return en & ~en_prev;
    endfunction

endpackage

// File: rtl/d_latch_sync.sv
// Clock-domain-safe D latch built from edge-triggered flops only.
// While enable is high, q follows d combinationally; while enable is low,
// q shows the value captured on the last rising clk edge with enable high.
// Ports:
//   clk          in   1       system clock, all state updates on rising edge
//   reset        in   1       synchronous, active-high reset
//   d            in   WIDTH   data input
//   enable       in   1       latch gate: 1 = transparent, 0 = hold
//   q            out  WIDTH   latch output
//   transparent  out  1       1 while q is following d
//   open_cnt     out  CNT_W   enable 0->1 transitions seen since reset,
//                             saturating at all-ones
module d_latch_sync
    import d_latch_sync_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned CNT_W = DefCntW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic             enable,
    output logic [WIDTH-1:0] q,
    output logic             transparent,
    output logic [CNT_W-1:0] open_cnt
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic [WIDTH-1:0] hold_d, hold_q;
    logic             en_d, en_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        hold_d = hold_q;
        en_d   = enable;
        cnt_d  = cnt_q;
        if (enable) begin
            hold_d = d;
        end
        if (window_opens(enable, en_q) && (cnt_q != CntMax)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q <= '0;
            en_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            hold_q <= hold_d;
            en_q   <= en_d;
            cnt_q  <= cnt_d;
        end
    end

    // Reset overrides the output immediately, not only at the next edge.
    assign q           = reset ? '0 : (enable ? d : hold_q);
    assign transparent = enable & ~reset;
    assign open_cnt    = cnt_q;

endmodule

// File: tb/tb_d_latch_sync.sv
// Self-checking bench for d_latch_sync: a main instance (WIDTH=1, CNT_W=8)
// and a narrow-counter instance (CNT_W=2) for saturation.
module tb_d_latch_sync;

    logic       clk = 1'b0;
    logic       reset, enable;
    logic [0:0] d;
    logic [0:0] q;
    logic       transparent;
    logic [7:0] open_cnt;

    logic       s_reset, s_enable;
    logic [0:0] s_d;
    logic [0:0] s_q;
    logic       s_transparent;
    logic [1:0] s_open_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    d_latch_sync #(.WIDTH(1), .CNT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .d           (d),
        .enable      (enable),
        .q           (q),
        .transparent (transparent),
        .open_cnt    (open_cnt)
    );

    d_latch_sync #(.WIDTH(1), .CNT_W(2)) dut_s (
        .clk         (clk),
        .reset       (s_reset),
        .d           (s_d),
        .enable      (s_enable),
        .q           (s_q),
        .transparent (s_transparent),
        .open_cnt    (s_open_cnt)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic       din;
        logic       exp_q;
        logic       exp_tr;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        d      = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // state before each row: values follow from the previous rows
        vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd1};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
        vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2};
        vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
        vecs[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'd0};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};

        reset    = 1'b1;
        enable   = 1'b0;
        d        = 1'b1;
        s_reset  = 1'b1;
        s_enable = 1'b0;
        s_d      = 1'b0;
        #1;

        // 1. Reset
        check("reset_q_comb", q, 1'b0);
        check("reset_tr_comb", transparent, 1'b0);
        tick();
        tick();
        check("reset_q", q, 1'b0);
        check("reset_tr", transparent, 1'b0);
        check("reset_cnt", open_cnt, 8'd0);
        reset = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 10; i++) begin
            reset  = vecs[i].rst;
            enable = vecs[i].en;
            d      = vecs[i].din;
            #1;
            check($sformatf("vec%0d_q", i), q, vecs[i].exp_q);
            check($sformatf("vec%0d_tr", i), transparent, vecs[i].exp_tr);
            check($sformatf("vec%0d_cnt", i), open_cnt, vecs[i].exp_cnt);
            tick();
        end

        // 2. Transparency with mid-cycle d changes
        do_reset();
        enable = 1'b1;
        d      = 1'b0;
        #1 check("transp_d0", q, 1'b0);
        check("transp_tr", transparent, 1'b1);
        d = 1'b1;
        #1 check("transp_d1", q, 1'b1);
        d = 1'b0;
        #1 check("transp_d0b", q, 1'b0);

        // 3. Hold: d=1 captured, then d=0 and X must not show through
        d = 1'b1;
        tick();
        enable = 1'b0;
        d      = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i >= 5) d = 1'bx;
            #1 check($sformatf("hold_e%0d", i), q, 1'b1);
            tick();
        end
        check("hold_tr", transparent, 1'b0);

        // Change of d after the capturing edge is not retained
        enable = 1'b1;
        d      = 1'b0;
        tick();
        d = 1'b1;
        #1 check("late_d_transp", q, 1'b1);
        enable = 1'b0;
        #1 check("late_d_dropped", q, 1'b0);
        tick();

        // 4. Counting: 5 pulses of varying length, d = i & 1
        do_reset();
        for (int i = 0; i < 5; i++) begin
            int len;
            case (i)
                0: len = 1;
                1: len = 3;
                2: len = 7;
                3: len = 2;
                default: len = 5;
            endcase
            enable = 1'b1;
            d      = i[0];
            for (int k = 0; k < len; k++) tick();
            enable = 1'b0;
            d      = ~i[0];
            tick();
            tick();
        end
        check("count_cnt", open_cnt, 8'd5);
        check("count_q", q, 1'b0);

        // 5. Reset mid-window
        do_reset();
        enable = 1'b1;
        d      = 1'b1;
        tick();
        check("midrst_pre_cnt", open_cnt, 8'd1);
        reset = 1'b1;
        #1 check("midrst_q_during", q, 1'b0);
        check("midrst_tr_during", transparent, 1'b0);
        tick();
        check("midrst_cnt_cleared", open_cnt, 8'd0);
        reset = 1'b0;
        #1 check("midrst_q_after", q, 1'b1);
        tick();
        check("midrst_cnt_after", open_cnt, 8'd1);
        enable = 1'b0;
        d      = 1'b0;
        #1 check("midrst_hold", q, 1'b1);
        tick();

        // 6. Saturation on the CNT_W=2 instance
        tick();
        tick();
        s_reset = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            s_enable = 1'b1;
            s_d      = 1'b1;
            tick();
            s_enable = 1'b0;
            tick();
            check($sformatf("sat_p%0d", i), s_open_cnt, (i > 3) ? 32'd3 : i);
        end
        for (int i = 0; i < 4; i++) tick();
        check("sat_stays", s_open_cnt, 2'd3);
        check("sat_q", s_q, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
